jtag_rpc_mbox_reg: RTL

- Bidirectional JTAG RPC mailbox data register. It is the successor to the capture/shift-only RPC input register.
- Adds an update path that issues requests to the core with a valid/ready handshake.
- Adds a parametrised DEPTH response FIFO that is drained by capture_dr.
- Adds status bits and a sticky error flag.
- Sits between the TAP controller decode (select, capture_dr, shift_dr, update_dr) and a core-side RPC engine, all on the TAP clock.

---
 rtl/jtag_rpc_mbox_reg.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/jtag_rpc_mbox_reg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_rpc_mbox_reg
// Description : Bidirectional JTAG RPC mailbox data register. Capture returns
//               status plus the head of a response FIFO, which is popped as it
//               is read. Update issues a request to the core over a
//               valid/ready handshake. A sticky error flag records dropped
//               requests. Everything runs on the TAP clock.
//               Optional macro JTAG_RPC_MBOX_PARITY_EN adds an even-parity
//               bit at the top of the scan word, generated on capture and
//               checked on update.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_rpc_mbox_reg #(
    parameter int              BITS        = 16,
    parameter int              DEPTH       = 4,
    parameter logic [BITS-1:0] RESET_VALUE = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            select,
    input  logic            capture_dr,
    input  logic            shift_dr,
    input  logic            update_dr,
    input  logic            tdi,
    output logic            tdo,
    output logic [BITS-1:0] req_data,
    output logic            req_valid,
    input  logic            req_ready,
    input  logic [BITS-1:0] rsp_data,
    input  logic            rsp_valid,
    output logic            rsp_ready,
    output logic            err
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;
`ifdef JTAG_RPC_MBOX_PARITY_EN
    localparam int c_W  = BITS + 4;
`else
    localparam int c_W  = BITS + 3;
`endif
    localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
    localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(DEPTH);

    logic [c_W-1:0]  r_sr;
    logic [BITS-1:0] r_req_data;
    logic            r_req_valid;
    logic            r_err;
    logic [BITS-1:0] r_mem [DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    logic            w_cap;
    logic            w_shift;
    logic            w_upd;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic [BITS-1:0] w_cap_head;
    logic [c_W-1:0]  w_cap_word;
    logic [BITS-1:0] w_payload;
    logic            w_par_ok;
    logic            w_go;
    logic            w_clr;
    logic            w_accept;
    logic            w_drop;

    // TAP events, capture beats shift beats update
    assign w_cap   = select & capture_dr;
    assign w_shift = select & shift_dr & ~capture_dr;
    assign w_upd   = select & update_dr & ~capture_dr & ~shift_dr;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_DEPTH);
    assign rsp_ready = ~w_full;
    assign w_push    = rsp_valid & ~w_full;
    // Capture reads the pre-push state, so a push into an empty FIFO in the
    // same cycle is not popped and stays for the next capture.
    assign w_pop     = w_cap & ~w_empty;

    assign w_cap_head = w_empty ? '0 : r_mem[r_rd_ptr];

`ifdef JTAG_RPC_MBOX_PARITY_EN
    assign w_cap_word = {^w_cap_head, w_cap_head, r_err, ~w_empty, r_req_valid};
    assign w_par_ok   = ~(^r_sr[c_W-1:3]);
`else
    assign w_cap_word = {w_cap_head, r_err, ~w_empty, r_req_valid};
    assign w_par_ok   = 1'b1;
`endif

    assign w_payload = r_sr[BITS+2:3];
    assign w_go      = w_upd & r_sr[0];
    assign w_clr     = w_upd & r_sr[1];
    // A new request may land in the same cycle the old one retires
    assign w_accept  = w_go & w_par_ok & (~r_req_valid | req_ready);
    assign w_drop    = w_go & ~w_accept;

    assign tdo       = r_sr[0];
    assign req_data  = r_req_data;
    assign req_valid = r_req_valid;
    assign err       = r_err;

    // Scan shift register: capture status/response, shift LSB first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sr <= '0;
        end else if (w_cap) begin
            r_sr <= w_cap_word;
        end else if (w_shift) begin
            r_sr <= {tdi, r_sr[c_W-1:1]};
        end
    end

    // Request register: load on accepted update, retire on handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_req_data  <= RESET_VALUE;
            r_req_valid <= 1'b0;
        end else if (w_accept) begin
            r_req_data  <= w_payload;
            r_req_valid <= 1'b1;
        end else if (r_req_valid && req_ready) begin
            r_req_valid <= 1'b0;
        end
    end

    // Sticky error: a drop in the same update as a clear keeps it set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_drop) begin
            r_err <= 1'b1;
        end else if (w_clr) begin
            r_err <= 1'b0;
        end
    end

    // Response FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Response FIFO storage; contents are only visible while non-empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rsp_data;
        end
    end

endmodule
`default_nettype wire
